// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stage indices, StallBus
// width and select-field width helpers.
package pipe_ctrl_pkg;

  typedef enum int {
    STG_NONE = 0,
    STG_IF   = 1,
    STG_ID   = 2,
    STG_EX   = 3,
    STG_MEM  = 4,
    STG_WB   = 5
  } stage_e;

  localparam int NSTAGE_DEF     = 5;
  localparam int CNT_W_DEF      = 32;
  localparam int WDOG_LIMIT_DEF = 1023;

  // Hold vector carries the PC bit plus one bit per stage register.
  function automatic int stallbus_w(input int nstage);
    return nstage + 1;
  endfunction

  // Width of a stage index able to encode 0 (none) through nstage.
  function automatic int sel_w(input int nstage);
    return $clog2(nstage + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the stage modules (master) and the pipeline controller (slave).
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

   localparam int SEL_W = sel_w(NSTAGE);
   localparam int SB_W  = stallbus_w(NSTAGE);

   logic              fetch_valid;
   logic [NSTAGE-1:0] stallreq;
   logic              flush;
   logic [SEL_W-1:0]  flush_upto;
   logic [SEL_W-1:0]  cnt_sel;
   logic              cnt_clr;
   logic [SB_W-1:0]   stall;
   logic [NSTAGE-1:0] bubble;
   logic [NSTAGE-1:0] flush_o;
   logic [NSTAGE-1:0] stage_valid;
   logic [CNT_W-1:0]  cnt_rdata;
   logic              wdog_err;

   modport master (
      output fetch_valid, stallreq, flush, flush_upto, cnt_sel, cnt_clr,
      input  stall, bubble, flush_o, stage_valid, cnt_rdata, wdog_err
   );

   modport slave (
      input  fetch_valid, stallreq, flush, flush_upto, cnt_sel, cnt_clr,
      output stall, bubble, flush_o, stage_valid, cnt_rdata, wdog_err
   );

endinterface

// File: rtl/pipe_stall_enc.sv
// Masked priority encoder: returns the highest stage whose stall request is
// honoured (valid and not being flushed), or 0 when none is.
module pipe_stall_enc
  import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE = NSTAGE_DEF,
   parameter int SEL_W  = sel_w(NSTAGE)
) (
   input  logic [NSTAGE-1:0] stallreq,
   input  logic [NSTAGE-1:0] valid,
   input  logic [NSTAGE-1:0] flush_mask,
   output logic [SEL_W-1:0]  k
);

   // NOTE: k gets a default before the loop so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      k = '0;
      for (int s = 1; s <= NSTAGE; s++) begin
         if (stallreq[s-1] && valid[s-1] && !flush_mask[s-1]) k = SEL_W'(s);
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: hold vector, bubble and flush strobes, per-stage valid
// tracking, per-stage stall-cycle counters and a PC-stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE     = NSTAGE_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
   input logic       clk,
   input logic       rst,
   pipe_ctrl_if.slave bus
);

   localparam int SEL_W = sel_w(NSTAGE);
   localparam int SB_W  = stallbus_w(NSTAGE);
   localparam int RUN_W = (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT + 1) : 1;
   localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(WDOG_LIMIT);

   logic [NSTAGE-1:0] valid_q;
   logic [NSTAGE-1:0] flush_mask;
   logic [NSTAGE-1:0] bubble_v;
   logic [NSTAGE-1:0] valid_prev;
   logic [SB_W-1:0]   stall_v;
   logic [SEL_W-1:0]  k;
   logic [CNT_W-1:0]  cnt_q [NSTAGE];
   logic [RUN_W-1:0]  run_q;
   logic              wdog_q;

   // flush_upto beyond NSTAGE naturally selects every stage.
   always_comb begin
      flush_mask = '0;
      for (int s = 1; s <= NSTAGE; s++) begin
         flush_mask[s-1] = bus.flush && (s <= int'(bus.flush_upto));
      end
   end

   pipe_stall_enc #(.NSTAGE(NSTAGE), .SEL_W(SEL_W)) u_enc (
      .stallreq   (bus.stallreq),
      .valid      (valid_q),
      .flush_mask (flush_mask),
      .k          (k)
   );

   // Hold PC and stages 1..k; the stage just past k takes the bubble.
   always_comb begin
      stall_v  = '0;
      bubble_v = '0;
      if (k != '0) begin
         for (int j = 0; j < SB_W; j++) stall_v[j] = (j <= int'(k));
         for (int s = 1; s <= NSTAGE; s++) bubble_v[s-1] = (s == int'(k) + 1);
      end
   end

   assign valid_prev = {valid_q[NSTAGE-2:0], bus.fetch_valid};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
      end else begin
         for (int s = 0; s < NSTAGE; s++) begin
            if (flush_mask[s])     valid_q[s] <= 1'b0;
            else if (stall_v[s+1]) valid_q[s] <= valid_q[s];
            else if (bubble_v[s])  valid_q[s] <= 1'b0;
            else                   valid_q[s] <= valid_prev[s];
         end
      end
   end

   // NOTE: the counter array is a handful of flops readable by software, so it
   // is reset explicitly rather than left to power-up contents.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < NSTAGE; s++) cnt_q[s] <= '0;
      end else begin
         for (int s = 0; s < NSTAGE; s++) begin
            if (bus.cnt_clr && int'(bus.cnt_sel) == s + 1)
               cnt_q[s] <= '0;
            else if (int'(k) == s + 1 && cnt_q[s] != '1)
               cnt_q[s] <= cnt_q[s] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      bus.cnt_rdata = '0;
      for (int s = 0; s < NSTAGE; s++) begin
         if (int'(bus.cnt_sel) == s + 1) bus.cnt_rdata = cnt_q[s];
      end
   end

   // The error is raised on the same edge the run counter reaches the limit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         run_q  <= '0;
         wdog_q <= 1'b0;
      end else begin
         if (!stall_v[0])           run_q <= '0;
         else if (run_q != RUN_LIM) run_q <= run_q + RUN_W'(1);

         if (WDOG_LIMIT != 0 && stall_v[0] && run_q == RUN_LIM - RUN_W'(1))
            wdog_q <= 1'b1;
      end
   end

   assign bus.stall       = stall_v;
   assign bus.bubble      = bubble_v;
   assign bus.flush_o     = flush_mask;
   assign bus.stage_valid = valid_q;
   assign bus.wdog_err    = wdog_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (NSTAGE=5, WDOG_LIMIT=4): vector table for the
// per-cycle behaviour, hand sequences for watchdog, counter clear and reset.
module tb_pipe_ctrl;

   typedef struct {
      string      name;
      logic       r;
      logic       fv;
      logic [4:0] sreq;
      logic       fl;
      logic [2:0] fup;
      logic [2:0] sel;
      logic       clr;
      logic [5:0] e_stall;
      logic [4:0] e_bubble;
      logic [4:0] e_flush;
      logic [4:0] e_valid;
      logic [31:0] e_rdata;
      logic       e_wdog;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t vq[$];

   pipe_ctrl_if #(.NSTAGE(5), .CNT_W(32)) bus ();

   pipe_ctrl #(.NSTAGE(5), .CNT_W(32), .WDOG_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic r, input logic fv, input logic [4:0] sreq,
                      input logic fl, input logic [2:0] fup, input logic [2:0] sel, input logic clr,
                      input logic [5:0] e_stall, input logic [4:0] e_bubble, input logic [4:0] e_flush,
                      input logic [4:0] e_valid, input logic [31:0] e_rdata, input logic e_wdog);
      vec_t v;
      v.name = name; v.r = r; v.fv = fv; v.sreq = sreq; v.fl = fl; v.fup = fup;
      v.sel = sel; v.clr = clr; v.e_stall = e_stall; v.e_bubble = e_bubble;
      v.e_flush = e_flush; v.e_valid = e_valid; v.e_rdata = e_rdata; v.e_wdog = e_wdog;
      vq.push_back(v);
   endtask

   task automatic drive(input logic r, input logic fv, input logic [4:0] sreq, input logic fl,
                        input logic [2:0] fup, input logic [2:0] sel, input logic clr);
      rst = r; bus.fetch_valid = fv; bus.stallreq = sreq; bus.flush = fl;
      bus.flush_upto = fup; bus.cnt_sel = sel; bus.cnt_clr = clr;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      drive(1'b0, 1'b0, 5'b11111, 1'b0, 3'd0, 3'd0, 1'b0);
      tick();
      tick();

      //   name            r  fv sreq      fl fup sel clr  stall      bubble    flush_o   valid     rdata wdog
      add("rst_a",         0, 0, 5'b11111, 0, 0,  1,  0,   6'b000000, 5'b00000, 5'b00000, 5'b00000, 0, 0);
      add("rst_b",         0, 0, 5'b11111, 0, 0,  3,  0,   6'b000000, 5'b00000, 5'b00000, 5'b00000, 0, 0);
      add("rst_flush",     0, 0, 5'b11111, 1, 2,  5,  0,   6'b000000, 5'b00000, 5'b00011, 5'b00000, 0, 0);
      add("fill1",         1, 1, 5'b00000, 0, 0,  0,  0,   6'b000000, 5'b00000, 5'b00000, 5'b00000, 0, 0);
      add("fill2",         1, 1, 5'b00000, 0, 0,  0,  0,   6'b000000, 5'b00000, 5'b00000, 5'b00001, 0, 0);
      add("fill3",         1, 1, 5'b00000, 0, 0,  0,  0,   6'b000000, 5'b00000, 5'b00000, 5'b00011, 0, 0);
      add("fill4",         1, 1, 5'b00000, 0, 0,  0,  0,   6'b000000, 5'b00000, 5'b00000, 5'b00111, 0, 0);
      add("fill5",         1, 1, 5'b00000, 0, 0,  0,  0,   6'b000000, 5'b00000, 5'b00000, 5'b01111, 0, 0);
      add("id_stall",      1, 1, 5'b00010, 0, 0,  2,  0,   6'b000111, 5'b00100, 5'b00000, 5'b11111, 0, 0);
      add("nested",        1, 1, 5'b01010, 0, 0,  2,  0,   6'b011111, 5'b10000, 5'b00000, 5'b11011, 1, 0);
      add("nested_cnt4",   1, 1, 5'b00000, 0, 0,  4,  0,   6'b000000, 5'b00000, 5'b00000, 5'b01011, 1, 0);
      add("cnt2_kept",     1, 1, 5'b00000, 0, 0,  2,  0,   6'b000000, 5'b00000, 5'b00000, 5'b10111, 1, 0);
      add("sel_oob",       1, 1, 5'b00000, 0, 0,  6,  0,   6'b000000, 5'b00000, 5'b00000, 5'b01111, 0, 0);
      add("flush_vs_stall",1, 1, 5'b00100, 1, 3,  3,  0,   6'b000000, 5'b00000, 5'b00111, 5'b11111, 0, 0);
      add("post_flush",    1, 1, 5'b00000, 0, 0,  3,  0,   6'b000000, 5'b00000, 5'b00000, 5'b11000, 0, 0);
      add("flush_all",     1, 1, 5'b11111, 1, 7,  0,  0,   6'b000000, 5'b00000, 5'b11111, 5'b10001, 0, 0);
      add("flush_none",    1, 1, 5'b00001, 1, 0,  0,  0,   6'b000000, 5'b00000, 5'b00000, 5'b00000, 0, 0);
      add("if_stall",      1, 1, 5'b00001, 0, 0,  1,  0,   6'b000011, 5'b00010, 5'b00000, 5'b00001, 0, 0);
      add("if_cnt",        1, 1, 5'b00000, 0, 0,  1,  0,   6'b000000, 5'b00000, 5'b00000, 5'b00001, 1, 0);
      add("refill_a",      1, 1, 5'b00000, 0, 0,  0,  0,   6'b000000, 5'b00000, 5'b00000, 5'b00011, 0, 0);
      add("refill_b",      1, 1, 5'b00000, 0, 0,  0,  0,   6'b000000, 5'b00000, 5'b00000, 5'b00111, 0, 0);
      add("refill_c",      1, 1, 5'b00000, 0, 0,  0,  0,   6'b000000, 5'b00000, 5'b00000, 5'b01111, 0, 0);

      foreach (vq[i]) begin
         drive(vq[i].r, vq[i].fv, vq[i].sreq, vq[i].fl, vq[i].fup, vq[i].sel, vq[i].clr);
         @(negedge clk);
         check($sformatf("%s.stall", vq[i].name),   32'(bus.stall),       32'(vq[i].e_stall));
         check($sformatf("%s.bubble", vq[i].name),  32'(bus.bubble),      32'(vq[i].e_bubble));
         check($sformatf("%s.flush_o", vq[i].name), 32'(bus.flush_o),     32'(vq[i].e_flush));
         check($sformatf("%s.valid", vq[i].name),   32'(bus.stage_valid), 32'(vq[i].e_valid));
         check($sformatf("%s.rdata", vq[i].name),   bus.cnt_rdata,        vq[i].e_rdata);
         check($sformatf("%s.wdog", vq[i].name),    32'(bus.wdog_err),    32'(vq[i].e_wdog));
         tick();
      end

      // Watchdog: WB request on a full pipe holds everything; error on 4th edge.
      check("wd.valid_full", 32'(bus.stage_valid), 32'h1f);
      drive(1'b1, 1'b1, 5'b10000, 1'b0, 3'd0, 3'd5, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check($sformatf("wd.stall%0d", i),  32'(bus.stall),  32'h3f);
         check($sformatf("wd.bubble%0d", i), 32'(bus.bubble), 32'h00);
         tick();
         check($sformatf("wd.err%0d", i), 32'(bus.wdog_err), (i >= 4) ? 32'd1 : 32'd0);
      end
      check("wd.cnt5", bus.cnt_rdata, 32'd4);

      // Clear wins over a same-cycle increment.
      bus.cnt_clr = 1'b1;
      tick();
      check("clr.cnt5", bus.cnt_rdata, 32'd0);
      check("clr.err_sticky", 32'(bus.wdog_err), 32'd1);

      bus.cnt_clr  = 1'b0;
      bus.stallreq = 5'b00000;
      tick();
      check("drop.err_sticky", 32'(bus.wdog_err), 32'd1);
      check("drop.stall", 32'(bus.stall), 32'h00);
      check("drop.valid", 32'(bus.stage_valid), 32'h1f);
      check("drop.cnt5", bus.cnt_rdata, 32'd0);

      // Reset mid-stall: holds drop right after the reset edge.
      bus.stallreq = 5'b00100;
      @(negedge clk);
      check("mid.stall_pre", 32'(bus.stall), 32'h0f);
      rst = 1'b0;
      tick();
      @(negedge clk);
      check("mid.stall_post", 32'(bus.stall), 32'h00);
      check("mid.bubble_post", 32'(bus.bubble), 32'h00);
      check("mid.valid_post", 32'(bus.stage_valid), 32'h00);
      check("mid.err_cleared", 32'(bus.wdog_err), 32'd0);
      for (int s = 0; s < 8; s++) begin
         bus.cnt_sel = 3'(s);
         #1;
         check($sformatf("mid.cnt_sel%0d", s), bus.cnt_rdata, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline controller for the in-order MIPS core. It generalises the per-stage stall generation to NSTAGE stages and adds state the core does not yet have: per-stage valid tracking, bubble insertion, targeted flush, a stall watchdog, and per-stage stall-cycle counters. It sits beside the stage modules, takes their stall requests and the branch/exception flush, and drives the StallBus-style hold vector plus per-stage bubble and flush strobes.

## Interface
Parameters:
- NSTAGE, 5, number of pipeline stages, indexed 1..NSTAGE (1=IF … NSTAGE=WB)
- CNT_W, 32, width of each stall-cycle counter
- WDOG_LIMIT, 1023, consecutive PC-stall cycles that set wdog_err; 0 disables the watchdog

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- fetch_valid  in  1  IF produced a valid instruction this cycle
- stallreq  in  NSTAGE  bit s-1 = stage s requests a stall
- flush  in  1  flush request (branch mispredict / exception)
- flush_upto  in  $clog2(NSTAGE+1)  flush stages 1..flush_upto
- cnt_sel  in  $clog2(NSTAGE+1)  counter read select (1..NSTAGE)
- cnt_clr  in  1  clear the selected counter
- stall  out  NSTAGE+1  bit 0 = hold PC; bit s = hold stage-s output register
- bubble  out  NSTAGE  bit s-1 = stage s register loads a bubble
- flush_o  out  NSTAGE  bit s-1 = stage s register is cleared
- stage_valid  out  NSTAGE  bit s-1 = stage s holds a valid instruction
- cnt_rdata  out  CNT_W  value of counter cnt_sel; 0 when cnt_sel is 0 or >NSTAGE
- wdog_err  out  1  sticky watchdog error

## Operation
- Honoured request: stallreq[s] counts only if stage_valid[s]=1 and stage s is not flushed this cycle (flush=1 and s<=flush_upto).
- k = highest honoured requesting stage; k=0 if none.
- stall[j]=1 for 0<=j<=k, else 0. bubble[k+1]=1 if 1<=k<NSTAGE; all other bubble bits 0.
- flush_o[s]=flush & (s<=flush_upto). flush_upto=0 flushes nothing; values >NSTAGE flush all stages.
- stage_valid[s] next value, evaluated in priority order:
  - flush_o[s]: 0
  - stall[s]: hold
  - bubble[s]: 0
  - otherwise: fetch_valid for s=1, stage_valid[s-1] for s>1
- Counters: cnt[k] increments each cycle with k>=1. It saturates at all-ones. cnt_clr zeroes cnt[cnt_sel], and clear wins over increment in the same cycle.
- Watchdog:
  - A run counter increments while stall[0]=1 and resets to 0 when stall[0]=0.
  - When WDOG_LIMIT!=0 and the run counter reaches WDOG_LIMIT, wdog_err is set; it clears only on reset.
  - The run counter saturates at WDOG_LIMIT.

## Timing
- stall, bubble, flush_o and cnt_rdata are combinational from the current inputs and registered state, with zero latency.
- stage_valid, the counters and wdog_err update at the next rising edge.
- Reset (rst=0 at an edge): stage_valid=0, all cnt=0, run counter=0, wdog_err=0.
  - With stage_valid=0 every request is masked, so stall=0 and bubble=0 during and after reset.
  - flush_o still follows flush combinationally.
- Reset mid-stall drops all holds in the cycle after the reset edge; no request state is retained.
- Simultaneous flush and a higher-stage stall:
  - The stall holds stages above flush_upto.
  - Flushed stages clear regardless of stall.
  - A bubble is not separately reported for a flushed stage.
- Request from stage NSTAGE: the whole pipe holds and no bubble is generated.

## Structure
- pipe_ctrl_pkg:
  - stage index constants (IF=1, ID=2, EX=3, MEM=4, WB=5 for the default build)
  - StallBus width function NSTAGE+1
  - counter-width localparam
- Sub-module pipe_stall_enc: masked priority encoder, stallreq & valid & ~flush_mask → k. It is purely combinational and reused by all stall/bubble logic.
- Counters are a register array indexed by stage, with a single read mux.

## Test plan
All scenarios use the default NSTAGE=5.
- Reset: rst=0 for 3 cycles, stallreq=5'b11111, flush=0 → stall=6'b0, bubble=0, stage_valid=0, cnt_rdata=0 for every cnt_sel, wdog_err=0.
- Fill: rst=1, fetch_valid=1 for 5 cycles, no requests → stage_valid steps 00001, 00011, 00111, 01111, 11111.
- ID stall with full pipe: stallreq=5'b00010 for 1 cycle → stall=6'b000111, bubble=5'b00100. Next cycle stage_valid=5'b11011, and cnt_sel=2 reads 1.
- Nested requests: stallreq=5'b01010 → stall=6'b011111, bubble=5'b10000. cnt[4] increments; cnt[2] is unchanged.
- Flush vs stall: full pipe, flush=1, flush_upto=3, stallreq=5'b00100 → request masked, stall=0, flush_o=5'b00111. Next stage_valid=5'b11000 (stages 4,5 advance; stage 4 loads old stage 3's valid then clears on the following cycle as fetch refills).
- Watchdog with WDOG_LIMIT=4: full pipe, stallreq[5]=1 held → wdog_err=1 after the 4th stall cycle edge. It stays 1 after stallreq drops and until rst=0. cnt_sel=5 then cnt_clr=1 → cnt_rdata=0 next cycle.
